uart_boot_loader: RTL
=====================

# uart_boot_loader

Serial program loader placed upstream of the core top level. Receives a framed program image over an 8N1 UART line, writes it word-by-word into instruction memory through a single write port, and holds the core in reset until a complete, checksum-valid image has been written. After a successful load it releases the core reset. On any protocol error it keeps the core in reset and flags the error.

## Interface
Parameters:
- CLK_FREQ_HZ, 50_000_000: frequency of i_clk.
- BAUD, 115_200: UART bit rate. DIVISOR = CLK_FREQ_HZ/BAUD (integer division) must be ≥ 4.
- ADDR_W, 10: word-address width of instruction memory.
- MAX_WORDS, 1024: largest accepted image, in words. Must be ≤ 2^ADDR_W.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_uart_rx  in  1  serial input; idles high; asynchronous to i_clk.
- o_imem_we  out  1  one-cycle instruction-memory write strobe.
- o_imem_addr  out  ADDR_W  word address of the write.
- o_imem_wdata  out  32  write data, assembled little-endian.
- o_core_reset_n  out  1  active-low reset to the core; registered.
- o_busy  out  1  high while states LEN0..CSUM are active.
- o_error  out  1  sticky error flag.

## Operation
- RX front end:
  - 2-flop synchronizer on i_uart_rx.
  - A falling edge starts a frame. Sample again at DIVISOR/2; if the line is high, treat it as a false start and return to idle.
  - Sample data bits LSB-first every DIVISOR cycles after that point, then sample the stop bit.
  - Stop bit = 1: emit a one-cycle byte_valid with the byte.
  - Stop bit = 0: emit a one-cycle frame_err and no byte.
- Frame format: 0xA5 magic, N_lo, N_hi (16-bit word count N), 4N data bytes, 1 checksum byte.
  - Each data word is little-endian: the first byte goes to bits [7:0].
  - Checksum = XOR of every byte after the magic (N_lo, N_hi and all data bytes).
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE: byte 0xA5 → LEN0. Other bytes and frame_err are ignored.
  - LEN0: store N_lo → LEN1.
  - LEN1: store N_hi.
    - N > MAX_WORDS → ERR.
    - N = 0 → CSUM.
    - Otherwise → DATA, with word index and byte count cleared.
  - DATA: shift each byte into the word register.
    - On the 4th byte, pulse o_imem_we with o_imem_addr = word index, then increment the index.
    - After word N-1 is written → CSUM.
  - CSUM: received byte equals the running XOR → DONE; otherwise → ERR.
  - DONE: terminal. o_core_reset_n = 1. Further RX bytes are ignored.
  - ERR: terminal. o_error = 1, o_core_reset_n = 0.
  - frame_err in LEN0, LEN1, DATA or CSUM → ERR.
  - Only i_reset_n exits DONE or ERR.
- Address arithmetic: word index is ADDR_W bits and starts at 0. It cannot wrap, because N ≤ MAX_WORDS ≤ 2^ADDR_W.
- o_imem_addr and o_imem_wdata are held stable from the cycle of the strobe until the next write.

## Timing
- Reset values: o_imem_we=0, o_imem_addr=0, o_imem_wdata=0, o_core_reset_n=0, o_busy=0, o_error=0, FSM=IDLE, RX idle.
- byte_valid fires exactly one cycle after the stop-bit sample.
- o_imem_we is high in the cycle after the byte_valid of each word's 4th byte, for exactly 1 cycle.
- o_core_reset_n rises 1 cycle after the byte_valid of a matching checksum byte, and stays high.
- o_error rises 1 cycle after the offending byte_valid or frame_err.
- o_busy rises 1 cycle after the magic byte_valid. It falls when DONE or ERR is entered.
- Asserting i_reset_n mid-load aborts immediately: all outputs return to reset values and the core is held in reset. Memory contents already written are not cleared.
- Minimum spacing between byte_valid events is 10·DIVISOR cycles. The FSM consumes one byte per cycle, so no buffering is required.

## Test plan
Bench settings: CLK_FREQ_HZ=1_000_000, BAUD=100_000 (DIVISOR=10), ADDR_W=4, MAX_WORDS=8.
- Single word: send A5 01 00 13 00 00 00, checksum 12.
  - Required: one o_imem_we pulse with addr=0, wdata=0x00000013.
  - o_core_reset_n=1 one cycle after the checksum byte; o_error=0.
- Two words: send A5 02 00 B7 12 34 00 13 05 10 00 with the correct XOR.
  - Required: writes addr0=0x003412B7 and addr1=0x00100513, in order; then DONE.
- Bad checksum: the single-word frame with checksum 13.
  - Required: o_error=1, o_core_reset_n stays 0, o_busy falls.
- Oversize: A5 09 00.
  - Required: ERR after N_hi; no write strobes.
- Noise and framing:
  - Bytes 00 FF before the magic are ignored.
  - A 5-cycle low glitch is rejected as a false start.
  - A stop bit of 0 during DATA → ERR.
- Reset mid-DATA: drop i_reset_n after 2 data bytes.
  - Required: all outputs return to reset values.
  - A full single-word frame re-sent afterwards loads correctly.

Source files
------------

// File: rtl/uart_boot_loader.sv
// Serial program loader: 8N1 UART receiver feeding a framed image (A5, N, 4N bytes, XOR) into imem,
// holding the core in reset until a checksum-valid image has been written. One byte per cycle, no stall.
module uart_boot_loader #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int ADDR_W      = 10,
    parameter int MAX_WORDS   = 1024
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_uart_rx,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_reset_n,
    output logic              o_busy,
    output logic              o_error
);

    localparam int DIVISOR = CLK_FREQ_HZ / BAUD;
    localparam int HALF    = DIVISOR / 2;
    localparam int CNT_W   = $clog2(DIVISOR + 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN0 = 3'd1;
    localparam logic [2:0] ST_LEN1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    localparam logic [7:0] MAGIC = 8'hA5;

    // ---------------- RX front end ----------------
    logic             rx_s1, rx_s2, rx_d;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    logic             frame_err;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= i_uart_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_d && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Mid-start-bit recheck rejects short glitches.
                    if (rx_cnt == CNT_W'(HALF - 1)) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            bit_idx  <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CNT_W'(DIVISOR - 1)) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == CNT_W'(DIVISOR - 1)) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- Frame FSM ----------------
    logic [2:0]        state;
    logic [7:0]        n_lo;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] widx;
    logic [1:0]        bcnt;
    logic [23:0]       wreg;
    logic [7:0]        csum;
    logic [15:0]       n_rx;

    assign n_rx   = {rx_shift, n_lo};
    assign o_busy = (state == ST_LEN0) || (state == ST_LEN1) ||
                    (state == ST_DATA) || (state == ST_CSUM);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= ST_IDLE;
            n_lo           <= '0;
            n_words        <= '0;
            widx           <= '0;
            bcnt           <= '0;
            wreg           <= '0;
            csum           <= '0;
            o_imem_we      <= 1'b0;
            o_imem_addr    <= '0;
            o_imem_wdata   <= '0;
            o_core_reset_n <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            o_imem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (byte_valid && rx_shift == MAGIC) begin
                        state <= ST_LEN0;
                        csum  <= '0;
                    end
                end
                ST_LEN0: begin
                    if (frame_err) begin
                        state   <= ST_ERR;
                        o_error <= 1'b1;
                    end else if (byte_valid) begin
                        n_lo  <= rx_shift;
                        csum  <= csum ^ rx_shift;
                        state <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (frame_err) begin
                        state   <= ST_ERR;
                        o_error <= 1'b1;
                    end else if (byte_valid) begin
                        n_words <= n_rx;
                        csum    <= csum ^ rx_shift;
                        if (32'(n_rx) > 32'(MAX_WORDS)) begin
                            state   <= ST_ERR;
                            o_error <= 1'b1;
                        end else if (n_rx == 16'd0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                            widx  <= '0;
                            bcnt  <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (frame_err) begin
                        state   <= ST_ERR;
                        o_error <= 1'b1;
                    end else if (byte_valid) begin
                        csum <= csum ^ rx_shift;
                        wreg <= {rx_shift, wreg[23:8]};
                        bcnt <= bcnt + 1'b1;
                        if (bcnt == 2'd3) begin
                            o_imem_we    <= 1'b1;
                            o_imem_addr  <= widx;
                            o_imem_wdata <= {rx_shift, wreg};
                            widx         <= widx + 1'b1;
                            if (32'(widx) == 32'(n_words) - 32'd1) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (frame_err) begin
                        state   <= ST_ERR;
                        o_error <= 1'b1;
                    end else if (byte_valid) begin
                        if (rx_shift == csum) begin
                            state          <= ST_DONE;
                            o_core_reset_n <= 1'b1;
                        end else begin
                            state   <= ST_ERR;
                            o_error <= 1'b1;
                        end
                    end
                end
                // DONE and ERR are terminal until reset.
                default: begin
                end
            endcase
        end
    end

endmodule
